// File: rtl/ed25519_host_bridge_pkg.sv
// ed25519_host_bridge_pkg
// Shared definitions for the ed25519 host bridge: channel and coordinate
// widths, word counts per transaction, FSM state encoding and the mapping
// from a 255-bit coordinate to one of its four 64-bit channel words.
// No ports (package).
package ed25519_host_bridge_pkg;

  localparam int WORD_W     = 64;
  localparam int COORD_W    = 255;
  localparam int N_TX_WORDS = 12;
  localparam int N_RX_WORDS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2,
    RESP = 2'd3
  } state_t;

  // Word 0 carries the top 63 bits of the coordinate with bit 63 padded to 0;
  // words 1..3 carry the remaining bits MSB-first.
  function automatic logic [WORD_W-1:0] coord_word(input logic [COORD_W-1:0] coord,
                                                   input logic [1:0]         idx);
    logic [WORD_W-1:0] w;
    case (idx)
      2'd0:    w = {1'b0, coord[254:192]};
      2'd1:    w = coord[191:128];
      2'd2:    w = coord[127:64];
      default: w = coord[63:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ed25519_word_packer.sv
// ed25519_word_packer
// Combinational word select/insert for one 255-bit coordinate.
//   i_coord   : coordinate being read (TX) or partially assembled (RX)
//   i_idx     : word index within the coordinate, 0 = most significant
//   i_word    : incoming 64-bit word to insert (RX)
//   o_word    : selected 64-bit word of i_coord (TX)
//   o_coord   : i_coord with i_word written at i_idx (RX)
//   o_pad_err : i_word has its padding bit set while i_idx == 0
module ed25519_word_packer
  import ed25519_host_bridge_pkg::*;
(
  input  logic [COORD_W-1:0] i_coord,
  input  logic [1:0]         i_idx,
  input  logic [WORD_W-1:0]  i_word,
  output logic [WORD_W-1:0]  o_word,
  output logic [COORD_W-1:0] o_coord,
  output logic               o_pad_err
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    o_word    = coord_word(i_coord, i_idx);
    o_coord   = i_coord;
    o_pad_err = 1'b0;
    case (i_idx)
      2'd0: begin
        // The padding bit is flagged but the payload bits are still stored.
        o_coord[254:192] = i_word[62:0];
        o_pad_err        = i_word[63];
      end
      2'd1:    o_coord[191:128] = i_word;
      2'd2:    o_coord[127:64]  = i_word;
      default: o_coord[63:0]    = i_word;
    endcase
  end

endmodule

// File: rtl/ed25519_host_bridge.sv
// ed25519_host_bridge
// Host-side initiator for the ed25519 scalar-multiply accelerator. Takes one
// parallel request {M, xp, yp}, streams it as 12 64-bit words, collects the
// 8 result words {xg, yg} and returns them as one parallel response.
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_req_valid/o_req_ready      : host request handshake; i_req_m/xp/yp data
//   o_tx_valid/i_tx_ready        : word stream to accelerator, o_tx_data
//   i_rx_valid/o_rx_ready        : word stream from accelerator, i_rx_data
//   o_rsp_valid/i_rsp_ready      : host response handshake; o_rsp_xg/yg data
//   o_rsp_err                    : malformed result word or receive timeout
//   o_busy                       : a transaction is in progress
// TIMEOUT_CYC bounds idle cycles between result words (0 disables).
module ed25519_host_bridge
  import ed25519_host_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [COORD_W-1:0]  i_req_m,
  input  logic [COORD_W-1:0]  i_req_xp,
  input  logic [COORD_W-1:0]  i_req_yp,
  output logic                o_tx_valid,
  input  logic                i_tx_ready,
  output logic [WORD_W-1:0]   o_tx_data,
  input  logic                i_rx_valid,
  output logic                o_rx_ready,
  input  logic [WORD_W-1:0]   i_rx_data,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [COORD_W-1:0]  o_rsp_xg,
  output logic [COORD_W-1:0]  o_rsp_yg,
  output logic                o_rsp_err,
  output logic                o_busy
);

  state_t                 r_state;
  logic [3*COORD_W-1:0]   r_buf;        // current operand always sits at the top
  logic [3:0]             r_cnt;        // word counter for SEND and RECV
  logic [31:0]            r_to_cnt;     // idle cycles since the last rx word
  logic [WORD_W-1:0]      r_tx_data;
  logic                   r_tx_valid;
  logic                   r_rx_ready;
  logic                   r_rsp_valid;
  logic                   r_rsp_err;
  logic                   r_malformed;
  logic [COORD_W-1:0]     r_xg;
  logic [COORD_W-1:0]     r_yg;

  logic                   w_tx_hs;
  logic                   w_rx_hs;
  logic [3:0]             w_cnt_next;
  logic                   w_timeout;
  logic                   w_is_send;
  logic [COORD_W-1:0]     w_pk_coord_in;
  logic [1:0]             w_pk_idx;
  logic [WORD_W-1:0]      w_pk_word;
  logic [COORD_W-1:0]     w_pk_coord;
  logic                   w_pk_pad_err;

  assign w_tx_hs    = r_tx_valid & i_tx_ready;
  assign w_rx_hs    = r_rx_ready & i_rx_valid;
  assign w_cnt_next = r_cnt + 4'd1;
  assign w_timeout  = (TIMEOUT_CYC != 0) && (r_to_cnt == TIMEOUT_CYC - 1);
  assign w_is_send  = (r_state == SEND);

  // SEND and RECV never overlap, so one packer serves both directions.
  // In SEND it prepares the word after the current one; when that word opens
  // a new operand it comes from the next slot of the buffer.
  assign w_pk_coord_in = w_is_send
                       ? ((w_cnt_next[1:0] == 2'd0) ? r_buf[2*COORD_W-1:COORD_W]
                                                    : r_buf[3*COORD_W-1:2*COORD_W])
                       : (r_cnt[2] ? r_yg : r_xg);
  assign w_pk_idx      = w_is_send ? w_cnt_next[1:0] : r_cnt[1:0];

  ed25519_word_packer u_packer (
    .i_coord   (w_pk_coord_in),
    .i_idx     (w_pk_idx),
    .i_word    (i_rx_data),
    .o_word    (w_pk_word),
    .o_coord   (w_pk_coord),
    .o_pad_err (w_pk_pad_err)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: r_buf is cleared on reset like everything else, but nothing reads
  // it before a request loads it; the reset exists only for determinism.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_buf       <= '0;
      r_cnt       <= '0;
      r_to_cnt    <= '0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_rx_ready  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_malformed <= 1'b0;
      r_xg        <= '0;
      r_yg        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_buf      <= {i_req_m, i_req_xp, i_req_yp};
            r_tx_data  <= coord_word(i_req_m, 2'd0);
            r_cnt      <= '0;
            r_tx_valid <= 1'b1;
            r_state    <= SEND;
          end
        end
        SEND: begin
          if (w_tx_hs) begin
            if (r_cnt == 4'(N_TX_WORDS - 1)) begin
              r_tx_valid  <= 1'b0;
              r_rx_ready  <= 1'b1;
              r_cnt       <= '0;
              r_to_cnt    <= '0;
              r_xg        <= '0;
              r_yg        <= '0;
              r_malformed <= 1'b0;
              r_rsp_err   <= 1'b0;
              r_state     <= RECV;
            end else begin
              r_cnt     <= w_cnt_next;
              r_tx_data <= w_pk_word;
              if (w_cnt_next[1:0] == 2'd0)
                r_buf <= {r_buf[2*COORD_W-1:0], {COORD_W{1'b0}}};
            end
          end
        end
        RECV: begin
          if (w_rx_hs) begin
            r_to_cnt    <= '0;
            r_malformed <= r_malformed | w_pk_pad_err;
            if (r_cnt[2]) r_yg <= w_pk_coord;
            else          r_xg <= w_pk_coord;
            if (r_cnt == 4'(N_RX_WORDS - 1)) begin
              r_rx_ready  <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= r_malformed | w_pk_pad_err;
              r_state     <= RESP;
            end else begin
              r_cnt <= w_cnt_next;
            end
          end else if (w_timeout) begin
            // Abort with whatever has been assembled so far.
            r_rx_ready  <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_ready = (r_state == IDLE);
  assign o_busy      = (r_state != IDLE);
  assign o_tx_valid  = r_tx_valid;
  assign o_tx_data   = r_tx_data;
  assign o_rx_ready  = r_rx_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_xg    = r_xg;
  assign o_rsp_yg    = r_yg;

endmodule

// File: tb/tb_ed25519_host_bridge.sv
// tb_ed25519_host_bridge
// Directed self-checking bench for ed25519_host_bridge (TIMEOUT_CYC = 50).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ed25519_host_bridge;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_req_valid;
  logic          o_req_ready;
  logic [254:0]  i_req_m, i_req_xp, i_req_yp;
  logic          o_tx_valid;
  logic          i_tx_ready;
  logic [63:0]   o_tx_data;
  logic          i_rx_valid;
  logic          o_rx_ready;
  logic [63:0]   i_rx_data;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [254:0]  o_rsp_xg, o_rsp_yg;
  logic          o_rsp_err;
  logic          o_busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] tx_words [12];
  int          tx_cnt;
  int          stall_bad;
  logic [63:0] rx_words [8];
  int          rx_gaps  [8];

  always #5 i_clk = ~i_clk;

  ed25519_host_bridge #(.TIMEOUT_CYC(50)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_m     (i_req_m),
    .i_req_xp    (i_req_xp),
    .i_req_yp    (i_req_yp),
    .o_tx_valid  (o_tx_valid),
    .i_tx_ready  (i_tx_ready),
    .o_tx_data   (o_tx_data),
    .i_rx_valid  (i_rx_valid),
    .o_rx_ready  (o_rx_ready),
    .i_rx_data   (i_rx_data),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_xg    (o_rsp_xg),
    .o_rsp_yg    (o_rsp_yg),
    .o_rsp_err   (o_rsp_err),
    .o_busy      (o_busy)
  );

  // ---------------- stimulus helpers ----------------
  task automatic send_req(input logic [254:0] m, input logic [254:0] xp, input logic [254:0] yp);
    int spin;
    spin = 0;
    while (!o_req_ready && spin < 20) begin @(negedge i_clk); spin++; end
    if (spin >= 20) begin n_cmp++; n_err++; $display("FAIL req_ready_wait: got 0 exp 1"); end
    i_req_valid = 1'b1; i_req_m = m; i_req_xp = xp; i_req_yp = yp;
    @(negedge i_clk);
    i_req_valid = 1'b0;
  endtask

  // Collects up to max_w tx words; toggle stalls every other cycle.
  task automatic collect_tx(input bit toggle, input int max_w);
    logic [63:0] held;
    bit          have_held;
    int          cyc;
    tx_cnt = 0; stall_bad = 0; have_held = 0; cyc = 0; held = '0;
    while (tx_cnt < max_w && cyc < 200) begin
      i_tx_ready = toggle ? 1'(cyc % 2) : 1'b1;
      if (o_tx_valid) begin
        if (have_held && held !== o_tx_data) stall_bad++;
        if (i_tx_ready) begin
          tx_words[tx_cnt] = o_tx_data;
          tx_cnt++;
          have_held = 0;
        end else begin
          held = o_tx_data;
          have_held = 1;
        end
      end
      @(negedge i_clk);
      cyc++;
    end
    i_tx_ready = 1'b0;
    if (tx_cnt != max_w) begin n_cmp++; n_err++; $display("FAIL tx_collect: got %0d words exp %0d", tx_cnt, max_w); end
  endtask

  task automatic feed_rx(input int n);
    int spin;
    for (int i = 0; i < n; i++) begin
      i_rx_valid = 1'b0;
      repeat (rx_gaps[i]) @(negedge i_clk);
      i_rx_valid = 1'b1;
      i_rx_data  = rx_words[i];
      spin = 0;
      while (!o_rx_ready && spin < 20) begin @(negedge i_clk); spin++; end
      if (spin >= 20) begin n_cmp++; n_err++; $display("FAIL rx_ready_wait: word %0d never accepted", i); end
      @(negedge i_clk);
    end
    i_rx_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!o_rsp_valid && n < 200) begin @(negedge i_clk); n++; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    n_cmp++;
    if ({o_tx_valid, o_rx_ready, o_rsp_valid, o_rsp_err, o_busy, o_tx_data, o_rsp_xg, o_rsp_yg} !== '0) begin
      n_err++; $display("FAIL reset_outputs: tx_v=%b rx_r=%b rsp_v=%b err=%b busy=%b exp all 0",
                        o_tx_valid, o_rx_ready, o_rsp_valid, o_rsp_err, o_busy);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if ({o_tx_valid, o_rx_ready, o_rsp_valid, o_rsp_err, o_busy, o_tx_data, o_rsp_xg, o_rsp_yg} !== '0) begin
      n_err++; $display("FAIL post_reset_outputs: tx_v=%b busy=%b exp 0", o_tx_valid, o_busy);
    end
    n_cmp++;
    if (o_req_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_req_ready: got %b exp 1", o_req_ready); end
  endtask

  task automatic test_basic_tx;
    logic [63:0] exp_w [12];
    for (int i = 0; i < 12; i++) exp_w[i] = 64'h0;
    exp_w[3] = 64'h1; exp_w[7] = 64'h1234; exp_w[11] = 64'h5678;
    // Garbage on the rx channel during SEND must be ignored.
    i_rx_valid = 1'b1; i_rx_data = '1;
    send_req(255'd1, 255'h1234, 255'h5678);
    n_cmp++;
    if ({o_tx_valid, o_busy, o_rx_ready} !== 3'b110) begin
      n_err++; $display("FAIL tx_valid_rise: got tx_v=%b busy=%b rx_r=%b exp 1 1 0", o_tx_valid, o_busy, o_rx_ready);
    end
    collect_tx(1'b0, 12);
    i_rx_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (tx_words[i] !== exp_w[i]) begin n_err++; $display("FAIL basic_tx_word%0d: got %h exp %h", i, tx_words[i], exp_w[i]); end
    end
    n_cmp++;
    if ({o_tx_valid, o_rx_ready} !== 2'b01) begin
      n_err++; $display("FAIL basic_tx_end: got tx_v=%b rx_r=%b exp 0 1", o_tx_valid, o_rx_ready);
    end
  endtask

  task automatic test_rx_reassembly;
    logic [254:0] exp_xg, exp_yg;
    int n;
    exp_xg = (255'd1 << 192) | 255'd2;
    exp_yg = 255'd3;
    rx_words = '{64'h1, 64'h0, 64'h0, 64'h2, 64'h0, 64'h0, 64'h0, 64'h3};
    rx_gaps  = '{0, 3, 1, 5, 2, 0, 4, 1};
    i_rsp_ready = 1'b0;
    feed_rx(8);
    wait_rsp(n);
    n_cmp++;
    if (n != 0) begin n_err++; $display("FAIL rsp_latency: got %0d cycles exp 0", n); end
    n_cmp++;
    if ({o_rsp_err, o_rsp_xg, o_rsp_yg} !== {1'b0, exp_xg, exp_yg}) begin
      n_err++; $display("FAIL rx_result: got err=%b xg=%h yg=%h exp err=0 xg=%h yg=%h", o_rsp_err, o_rsp_xg, o_rsp_yg, exp_xg, exp_yg);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      n_cmp++;
      if ({o_rsp_valid, o_rsp_err, o_rsp_xg, o_rsp_yg} !== {1'b1, 1'b0, exp_xg, exp_yg}) begin
        n_err++; $display("FAIL rsp_hold_c%0d: got valid=%b err=%b exp valid=1 err=0 with stable data", c, o_rsp_valid, o_rsp_err);
      end
    end
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    n_cmp++;
    if ({o_rsp_valid, o_busy, o_req_ready} !== 3'b001) begin
      n_err++; $display("FAIL rsp_release: got valid=%b busy=%b req_ready=%b exp 0 0 1", o_rsp_valid, o_busy, o_req_ready);
    end
    n_cmp++;
    if (o_rsp_xg !== exp_xg) begin n_err++; $display("FAIL xg_keep_after_rsp: got %h exp %h", o_rsp_xg, exp_xg); end
  endtask

  task automatic test_tx_stall;
    logic [63:0] exp_w [12];
    for (int i = 0; i < 12; i++) exp_w[i] = 64'h0;
    exp_w[0] = 64'h7FFF_FFFF_FFFF_FFFF;
    exp_w[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_w[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_w[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_w[4] = 64'h4000_0000_0000_0000;  // xp = 1 << 254
    exp_w[10] = 64'h1;                   // yp = 1 << 64
    send_req('1, 255'd1 << 254, 255'd1 << 64);
    collect_tx(1'b1, 12);
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (tx_words[i] !== exp_w[i]) begin n_err++; $display("FAIL stall_tx_word%0d: got %h exp %h", i, tx_words[i], exp_w[i]); end
    end
    n_cmp++;
    if (stall_bad != 0) begin n_err++; $display("FAIL stall_data_stable: got %0d changes exp 0", stall_bad); end
    n_cmp++;
    if (o_tx_valid !== 1'b0) begin n_err++; $display("FAIL stall_no_extra_word: got tx_v=%b exp 0", o_tx_valid); end
  endtask

  task automatic test_malformed;
    logic [254:0] exp_xg, exp_yg;
    int n;
    exp_xg = {63'h0, 64'h11, 64'h22, 64'h33};
    exp_yg = {63'h7FFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 64'h44};
    rx_words = '{64'h8000_0000_0000_0000, 64'h11, 64'h22, 64'h33,
                 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 64'h44};
    rx_gaps  = '{1, 0, 2, 0, 0, 1, 0, 0};
    feed_rx(8);
    wait_rsp(n);
    n_cmp++;
    if (o_rsp_valid !== 1'b1) begin n_err++; $display("FAIL malformed_rsp_valid: got %b exp 1", o_rsp_valid); end
    n_cmp++;
    if (o_rsp_err !== 1'b1) begin n_err++; $display("FAIL malformed_err: got %b exp 1", o_rsp_err); end
    n_cmp++;
    if ({o_rsp_xg, o_rsp_yg} !== {exp_xg, exp_yg}) begin
      n_err++; $display("FAIL malformed_data: got xg=%h yg=%h exp xg=%h yg=%h", o_rsp_xg, o_rsp_yg, exp_xg, exp_yg);
    end
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
  endtask

  task automatic test_timeout;
    logic [254:0] exp_xg;
    int n;
    exp_xg = {63'hAAAA, 64'hBBBB, 64'hCCCC, 64'h0};
    send_req(255'd5, 255'd6, 255'd7);
    collect_tx(1'b0, 12);
    rx_words = '{64'hAAAA, 64'hBBBB, 64'hCCCC, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    rx_gaps  = '{0, 0, 0, 0, 0, 0, 0, 0};
    feed_rx(3);
    wait_rsp(n);
    n_cmp++;
    if (n != 50) begin n_err++; $display("FAIL timeout_cycles: got %0d exp 50", n); end
    n_cmp++;
    if ({o_rsp_valid, o_rsp_err, o_rx_ready} !== 3'b110) begin
      n_err++; $display("FAIL timeout_flags: got valid=%b err=%b rx_r=%b exp 1 1 0", o_rsp_valid, o_rsp_err, o_rx_ready);
    end
    n_cmp++;
    if ({o_rsp_xg, o_rsp_yg} !== {exp_xg, 255'd0}) begin
      n_err++; $display("FAIL timeout_partial: got xg=%h yg=%h exp xg=%h yg=0", o_rsp_xg, o_rsp_yg, exp_xg);
    end
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    n_cmp++;
    if ({o_busy, o_rsp_valid, o_req_ready} !== 3'b001) begin
      n_err++; $display("FAIL timeout_to_idle: got busy=%b valid=%b req_ready=%b exp 0 0 1", o_busy, o_rsp_valid, o_req_ready);
    end
  endtask

  task automatic test_reset_mid;
    send_req(255'd9, 255'd10, 255'd11);
    collect_tx(1'b0, 5);
    i_rst = 1'b1;
    @(negedge i_clk);
    n_cmp++;
    if ({o_tx_valid, o_busy, o_rsp_valid} !== 3'b000) begin
      n_err++; $display("FAIL midreset_abort: got tx_v=%b busy=%b rsp_v=%b exp 0 0 0", o_tx_valid, o_busy, o_rsp_valid);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if ({o_req_ready, o_busy, o_tx_data} !== {1'b1, 1'b0, 64'h0}) begin
      n_err++; $display("FAIL midreset_release: got req_ready=%b busy=%b tx_data=%h exp 1 0 0", o_req_ready, o_busy, o_tx_data);
    end
  endtask

  task automatic test_after_reset;
    int n;
    send_req(255'd3, 255'h77, 255'h99);
    collect_tx(1'b0, 12);
    n_cmp++;
    if ({tx_words[0], tx_words[3], tx_words[7], tx_words[11]} !== {64'h0, 64'h3, 64'h77, 64'h99}) begin
      n_err++; $display("FAIL after_reset_tx: got w3=%h w7=%h w11=%h exp 3 77 99", tx_words[3], tx_words[7], tx_words[11]);
    end
    rx_words = '{64'h0, 64'h0, 64'h0, 64'hDEAD, 64'h0, 64'h0, 64'h0, 64'hBEEF};
    rx_gaps  = '{0, 0, 0, 0, 0, 0, 0, 0};
    feed_rx(8);
    wait_rsp(n);
    n_cmp++;
    if ({o_rsp_valid, o_rsp_err, o_rsp_xg, o_rsp_yg} !== {1'b1, 1'b0, 255'hDEAD, 255'hBEEF}) begin
      n_err++; $display("FAIL after_reset_rsp: got valid=%b err=%b xg=%h yg=%h exp 1 0 dead beef", o_rsp_valid, o_rsp_err, o_rsp_xg, o_rsp_yg);
    end
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    n_cmp++;
    if (o_busy !== 1'b0) begin n_err++; $display("FAIL after_reset_idle: got busy=%b exp 0", o_busy); end
  endtask

  initial begin
    i_rst = 1'b1; i_req_valid = 1'b0; i_req_m = '0; i_req_xp = '0; i_req_yp = '0;
    i_tx_ready = 1'b0; i_rx_valid = 1'b0; i_rx_data = '0; i_rsp_ready = 1'b0;
    test_reset();
    test_basic_tx();
    test_rx_reassembly();
    test_tx_stall();
    test_malformed();
    test_timeout();
    test_reset_mid();
    test_after_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1, "time limit");
  end

endmodule
